// File: rtl/dcache_mem_responder.sv
// Line-granular backing memory for the dcache miss/writeback path.
// One transaction at a time, fixed ack latency, out-of-range addresses flagged through err.
module dcache_mem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 128,
  parameter int OFFSET_BITS = 4,
  parameter int IDX_BITS    = 10,
  parameter int LATENCY     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dcache2mem_req_i,
  input  logic                  dcache2mem_wr_i,
  input  logic [ADDR_WIDTH-1:0] dcache2mem_addr_i,
  input  logic [LINE_WIDTH-1:0] dcache2mem_data_i,
  output logic [LINE_WIDTH-1:0] mem2dcache_data_o,
  output logic                  mem2dcache_ack_o,
  output logic                  mem2dcache_err_o,
  output logic                  busy_o
);

  localparam int IDX_HI = OFFSET_BITS + IDX_BITS;
  localparam int LINES  = 1 << IDX_BITS;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic                    wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LINE_WIDTH-1:0]   data_q;
  logic [IDX_BITS-1:0]     idx_q;
  logic                    oor_q;
  logic                    mem_we;
  logic [LINE_WIDTH-1:0]   mem [LINES];

  assign idx_q = addr_q[IDX_HI-1:OFFSET_BITS];

  generate
    if (ADDR_WIDTH > IDX_HI) begin : g_oor
      assign oor_q = |addr_q[ADDR_WIDTH-1:IDX_HI];
    end else begin : g_no_oor
      assign oor_q = 1'b0;
    end
  endgenerate

  // Byte-offset bits are captured with the request but never select anything.
  logic unused_offset;
  assign unused_offset = ^addr_q[OFFSET_BITS-1:0];

  // Storage write fires on the same edge that raises ack; reset blocks it.
  assign mem_we = rst_n && (state == WAIT) && (cnt == 4'd0) && wr_q && !oor_q;

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      cnt               <= 4'd0;
      wr_q              <= 1'b0;
      addr_q            <= '0;
      data_q            <= '0;
      mem2dcache_ack_o  <= 1'b0;
      mem2dcache_err_o  <= 1'b0;
      mem2dcache_data_o <= '0;
      busy_o            <= 1'b0;
    end else begin
      mem2dcache_ack_o <= 1'b0;
      mem2dcache_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (dcache2mem_req_i) begin
            wr_q   <= dcache2mem_wr_i;
            addr_q <= dcache2mem_addr_i;
            data_q <= dcache2mem_data_i;
            cnt    <= 4'(LATENCY - 1);
            busy_o <= 1'b1;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            mem2dcache_ack_o <= 1'b1;
            mem2dcache_err_o <= oor_q;
            if (!wr_q) mem2dcache_data_o <= oor_q ? '0 : mem[idx_q];
            state <= DROP;
          end
        end
        DROP: begin
          // Wait for the dcache to release req so a held request is not replayed.
          if (!dcache2mem_req_i) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Randomized scoreboard bench: driver pushes expected acks, a negedge monitor pops and compares.
// A second LATENCY=1 instance covers the minimum-latency timing.
module tb_dcache_mem_responder;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req = 1'b0, wr = 1'b0;
  logic [31:0]  addr = '0;
  logic [127:0] wdata = '0;
  logic [127:0] rdata;
  logic         ack, err, busy;

  logic         req1 = 1'b0, wr1 = 1'b0;
  logic [31:0]  addr1 = '0;
  logic [127:0] wdata1 = '0;
  logic [127:0] rdata1;
  logic         ack1, err1, busy1;

  dcache_mem_responder #(.LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .dcache2mem_req_i(req), .dcache2mem_wr_i(wr),
    .dcache2mem_addr_i(addr), .dcache2mem_data_i(wdata),
    .mem2dcache_data_o(rdata), .mem2dcache_ack_o(ack),
    .mem2dcache_err_o(err), .busy_o(busy)
  );

  dcache_mem_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .dcache2mem_req_i(req1), .dcache2mem_wr_i(wr1),
    .dcache2mem_addr_i(addr1), .dcache2mem_data_i(wdata1),
    .mem2dcache_data_o(rdata1), .mem2dcache_ack_o(ack1),
    .mem2dcache_err_o(err1), .busy_o(busy1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit           wr;
    bit           err;
    logic [127:0] data;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] mdl [int];   // backing store model, keyed by line index
  logic [127:0] last_rd = '0; // what data_o should be showing

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ack) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_ack", 128'd1, 128'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk(cyc == e.cyc, "ack_latency", 128'(cyc), 128'(e.cyc));
          chk(err == e.err, "ack_err", 128'(err), 128'(e.err));
          chk(rdata === e.data, e.wr ? "data_hold_on_write" : "read_data", rdata, e.data);
        end
      end else begin
        chk(err == 1'b0, "err_without_ack", 128'(err), 128'd0);
      end
    end
  end

  // Issue one transaction at a negedge; returns at a negedge with the DUT back in IDLE.
  task automatic issue(input bit w, input logic [31:0] a, input logic [127:0] d, input int hold);
    exp_t e;
    int   idx, n;
    bit   oor;
    idx = int'(a[13:4]);
    oor = |a[31:14];
    if (w) begin
      if (!oor) mdl[idx] = d;
    end else begin
      last_rd = oor ? 128'd0 : mdl[idx];
    end
    e.wr = w; e.err = oor; e.data = last_rd; e.cyc = cyc + 1 + LAT;
    sb.push_back(e);
    req = 1'b1; wr = w; addr = a; wdata = d;
    @(negedge clk);
    // Scramble inputs after acceptance: the captured copy must be used.
    wr = $urandom_range(0, 1); addr = $urandom; wdata = rnd128();
    n = 1;
    while (!ack && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ack) begin
      chk(1'b0, "ack_timeout", 128'd0, 128'd1);
      sb.delete();
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk(busy == 1'b1, "busy_while_held", 128'(busy), 128'd1);
    end
    req = 1'b0;
    @(negedge clk);
    chk(busy == 1'b0, "idle_after_release", 128'(busy), 128'd0);
  endtask

  task automatic l1_op(input bit w, input logic [31:0] a, input logic [127:0] d, input logic [127:0] exp);
    req1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d;
    @(negedge clk);
    chk(ack1 == 1'b0, "l1_no_early_ack", 128'(ack1), 128'd0);
    chk(busy1 == 1'b1, "l1_busy", 128'(busy1), 128'd1);
    @(negedge clk);
    chk(ack1 == 1'b1, "l1_ack", 128'(ack1), 128'd1);
    chk(err1 == 1'b0, "l1_err", 128'(err1), 128'd0);
    chk(rdata1 === exp, "l1_data", rdata1, exp);
    req1 = 1'b0;
    @(negedge clk);
    chk(busy1 == 1'b0, "l1_idle", 128'(busy1), 128'd0);
  endtask

  int pool [6] = '{0, 5, 'h12, 'h3FF, 7, 'h100};

  initial begin
    logic [127:0] d;
    logic [31:0]  a;
    int           c0;

    repeat (3) @(negedge clk);
    chk(rdata === 128'd0, "reset_data", rdata, 128'd0);
    chk(ack == 1'b0, "reset_ack", 128'(ack), 128'd0);
    chk(err == 1'b0, "reset_err", 128'(err), 128'd0);
    chk(busy == 1'b0, "reset_busy", 128'(busy), 128'd0);
    rst_n = 1'b1;

    foreach (pool[i]) issue(1'b1, 32'(pool[i]) << 4, rnd128(), 0);

    // Write then read the same line through a different byte offset.
    issue(1'b1, 32'h0000_0120, 128'h0123456789ABCDEF0123456789ABCDEF, 0);
    issue(1'b0, 32'h0000_012C, '0, 0);

    // Request held past ack must not be replayed.
    issue(1'b0, 32'h0000_0050, '0, 3);

    // Out-of-range read, then index 0 still intact.
    issue(1'b0, 32'h0001_0000, '0, 0);
    issue(1'b0, 32'h0000_0008, '0, 1);
    issue(1'b1, 32'h8000_0040, rnd128(), 0);
    issue(1'b0, 32'h0000_0040, '0, 0);

    // Reset in the second WAIT cycle aborts the write to index 5.
    req = 1'b1; wr = 1'b1; addr = 32'h0000_0050; wdata = rnd128();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0; req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = '0;
    chk(rdata === 128'd0, "midop_reset_data", rdata, 128'd0);
    chk(busy == 1'b0, "midop_reset_busy", 128'(busy), 128'd0);
    repeat (LAT + 2) @(negedge clk);
    issue(1'b0, 32'h0000_0054, '0, 0);

    // Random traffic over the pre-written lines.
    for (int t = 0; t < 40; t++) begin
      a = (32'(pool[$urandom_range(0, 5)]) << 4) | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) a = a | (32'd1 << (14 + $urandom_range(0, 17)));
      issue(1'(($urandom_range(0, 1))), a, rnd128(), $urandom_range(0, 2));
    end

    // Back-to-back write then read of one line with a single idle cycle.
    d = rnd128();
    c0 = cyc;
    issue(1'b1, 32'h0000_0070, d, 0);
    issue(1'b0, 32'h0000_0070, '0, 0);
    chk(cyc - c0 == 2 * (LAT + 2), "b2b_spacing", 128'(cyc - c0), 128'(2 * (LAT + 2)));

    // LATENCY=1 instance.
    d = rnd128();
    l1_op(1'b1, 32'h0000_0030, d, 128'd0);
    l1_op(1'b0, 32'h0000_003F, '0, d);

    repeat (4) @(negedge clk);
    chk(sb.size() == 0, "sb_drained", 128'(sb.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
